// File: rtl/ahb_apb_bridge_mc_if.sv
// AHB-Lite slave side and APB4 master side bundle for the multi-slave bridge.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface ahb_apb_bridge_mc_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_SLV = 4
);
   logic                        HSEL;
   logic [ADDR_W-1:0]           HADDR;
   logic                        HWRITE;
   logic [2:0]                  HSIZE;
   logic [1:0]                  HTRANS;
   logic                        HREADYIN;
   logic [DATA_W-1:0]           HWDATA;
   logic                        HREADYOUT;
   logic [1:0]                  HRESP;
   logic [DATA_W-1:0]           HRDATA;
   logic [ADDR_W-1:0]           PADDR;
   logic [NUM_SLV-1:0]          PSEL;
   logic                        PENABLE;
   logic                        PWRITE;
   logic [DATA_W-1:0]           PWDATA;
   logic [DATA_W/8-1:0]         PSTRB;
   logic [NUM_SLV-1:0]          PREADY;
   logic [NUM_SLV-1:0]          PSLVERR;
   logic [NUM_SLV*DATA_W-1:0]   PRDATA;

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYIN, HWDATA,
      input  PREADY, PSLVERR, PRDATA,
      output HREADYOUT, HRESP, HRDATA,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYIN, HWDATA,
      output PREADY, PSLVERR, PRDATA,
      input  HREADYOUT, HRESP, HRDATA,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );
endinterface

// File: rtl/ahb_apb_bridge_mc.sv
// Non-pipelined AHB-Lite to APB4 bridge fanning out to NUM_SLV decoded slaves,
// with PREADY wait states, byte strobes and two-cycle AHB ERROR responses.
module ahb_apb_bridge_mc #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_SLV = 4,
   parameter int unsigned SLV_LSB = 12
) (
   input logic                HCLK,
   input logic                HRESETn,
   ahb_apb_bridge_mc_if.slave bus
);
   localparam int unsigned IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_ERR  = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

   state_t               r_state, w_nx_state;
   logic                 r_hreadyout, w_nx_hreadyout;
   logic [1:0]           r_hresp, w_nx_hresp;
   logic [DATA_W-1:0]    r_hrdata, w_nx_hrdata;
   logic [ADDR_W-1:0]    r_paddr, w_nx_paddr;
   logic [NUM_SLV-1:0]   r_psel, w_nx_psel;
   logic                 r_penable, w_nx_penable;
   logic                 r_pwrite, w_nx_pwrite;
   logic [DATA_W-1:0]    r_pwdata, w_nx_pwdata;
   logic [STRB_W-1:0]    r_pstrb, w_nx_pstrb;
   logic [2:0]           r_size, w_nx_size;
   logic [IDX_W-1:0]     r_idx, w_nx_idx;

   logic                 w_valid;
   logic                 w_bad;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_pready;
   logic                 w_pslverr;
   logic [DATA_W-1:0]    w_prdata;

   function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_SLV-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++)
         if (idx == IDX_W'(i)) v[i] = 1'b1;
      return v;
   endfunction

   // Lanes covered by a transfer of 2**size bytes starting at byte offset off.
   function automatic logic [STRB_W-1:0] strb_mask(input logic [2:0] size,
                                                   input logic [OFF_W-1:0] off);
      logic [STRB_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < STRB_W; b++)
         m[b] = (b >= 32'(off)) && (b < 32'(off) + (32'd1 << size));
      return m;
   endfunction

   assign w_valid = bus.HSEL & bus.HREADYIN & (bus.HTRANS inside {2'b10, 2'b11});
   assign w_idx   = bus.HADDR[SLV_LSB +: IDX_W];
   assign w_bad   = (32'(w_idx) >= NUM_SLV) || ((32'd8 << bus.HSIZE) > DATA_W);

   // Only the latched slave's response bits and read data are observed.
   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_pready  = bus.PREADY[i];
            w_pslverr = bus.PSLVERR[i];
            w_prdata  = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= S_IDLE;
      else          r_state <= w_nx_state;
   end

   always_comb begin
      w_nx_state     = r_state;
      w_nx_hreadyout = r_hreadyout;
      w_nx_hresp     = r_hresp;
      w_nx_hrdata    = r_hrdata;
      w_nx_paddr     = r_paddr;
      w_nx_psel      = r_psel;
      w_nx_penable   = r_penable;
      w_nx_pwrite    = r_pwrite;
      w_nx_pwdata    = r_pwdata;
      w_nx_pstrb     = r_pstrb;
      w_nx_size      = r_size;
      w_nx_idx       = r_idx;
      case (r_state)
         // ERR2 completes the error, so the next address phase is sampled here too.
         S_IDLE, S_ERR2: begin
            w_nx_state     = S_IDLE;
            w_nx_hreadyout = 1'b1;
            w_nx_hresp     = RESP_OKAY;
            if (w_valid) begin
               w_nx_size      = bus.HSIZE;
               w_nx_idx       = w_idx;
               w_nx_hreadyout = 1'b0;
               if (w_bad) begin
                  w_nx_state = S_ERR1;
                  w_nx_hresp = RESP_ERR;
               end else begin
                  w_nx_paddr = bus.HADDR;
                  if (bus.HWRITE) begin
                     w_nx_state = S_WDATA;
                  end else begin
                     w_nx_state  = S_SETUP;
                     w_nx_psel   = onehot(w_idx);
                     w_nx_pwrite = 1'b0;
                     w_nx_pstrb  = '0;
                  end
               end
            end
         end
         S_WDATA: begin
            w_nx_state  = S_SETUP;
            w_nx_pwdata = bus.HWDATA;
            w_nx_pstrb  = strb_mask(r_size, r_paddr[OFF_W-1:0]);
            w_nx_psel   = onehot(r_idx);
            w_nx_pwrite = 1'b1;
         end
         S_SETUP: begin
            w_nx_state   = S_ACCESS;
            w_nx_penable = 1'b1;
         end
         S_ACCESS: begin
            if (w_pready) begin
               w_nx_psel    = '0;
               w_nx_penable = 1'b0;
               if (w_pslverr) begin
                  w_nx_state = S_ERR1;
                  w_nx_hresp = RESP_ERR;
               end else begin
                  w_nx_state     = S_IDLE;
                  w_nx_hreadyout = 1'b1;
                  if (!r_pwrite) w_nx_hrdata = w_prdata;
               end
            end
         end
         S_ERR1: begin
            w_nx_state     = S_ERR2;
            w_nx_hresp     = RESP_ERR;
            w_nx_hreadyout = 1'b1;
         end
         default: begin
            w_nx_state     = S_IDLE;
            w_nx_hreadyout = 1'b1;
            w_nx_hresp     = RESP_OKAY;
            w_nx_psel      = '0;
            w_nx_penable   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hreadyout <= 1'b1;
         r_hresp     <= RESP_OKAY;
         r_hrdata    <= '0;
         r_paddr     <= '0;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_size      <= '0;
         r_idx       <= '0;
      end else begin
         r_hreadyout <= w_nx_hreadyout;
         r_hresp     <= w_nx_hresp;
         r_hrdata    <= w_nx_hrdata;
         r_paddr     <= w_nx_paddr;
         r_psel      <= w_nx_psel;
         r_penable   <= w_nx_penable;
         r_pwrite    <= w_nx_pwrite;
         r_pwdata    <= w_nx_pwdata;
         r_pstrb     <= w_nx_pstrb;
         r_size      <= w_nx_size;
         r_idx       <= w_nx_idx;
      end
   end

   assign bus.HREADYOUT = r_hreadyout;
   assign bus.HRESP     = r_hresp;
   assign bus.HRDATA    = r_hrdata;
   assign bus.PADDR     = r_paddr;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PWDATA    = r_pwdata;
   assign bus.PSTRB     = r_pstrb;
endmodule
